// File: rtl/pifo_bypass_checker_mc_pkg.sv
// Shared scheduler helpers: descriptor field extraction and the rank-vs-top bypass compare.
package pifo_bypass_checker_mc_pkg;

    localparam int PIFO_INFO_WIDTH_DEF = 32;
    localparam int MAX_INFO_W          = 256;
    localparam int MAX_FIELD_W         = 64;

    // Descriptors wider than MAX_INFO_W or fields wider than MAX_FIELD_W are truncated.
    function automatic logic [MAX_FIELD_W-1:0] get_field(input logic [MAX_INFO_W-1:0] info,
                                                        input int lsb,
                                                        input int width);
        logic [MAX_FIELD_W-1:0] mask;
        mask = (MAX_FIELD_W'(1) << width) - MAX_FIELD_W'(1);
        return MAX_FIELD_W'(info >> lsb) & mask;
    endfunction

    function automatic logic bypass_cmp(input logic [MAX_FIELD_W-1:0] rank,
                                        input logic [MAX_FIELD_W-1:0] top,
                                        input logic nonempty,
                                        input logic tie);
        if (!nonempty) return 1'b1;
        return tie ? (rank <= top) : (rank < top);
    endfunction

endpackage

// File: rtl/pifo_bypass_shadow.sv
// Per-channel shadow of the last calendar-bound rank, valid for exactly one cycle after the
// handshake, standing in for the calendar top until the calendar has absorbed the entry.
module pifo_bypass_shadow #(
    parameter int NUM_CH     = 4,
    parameter int RANK_WIDTH = 16,
    parameter int CH_WIDTH   = 2
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         load_i,
    input  logic [CH_WIDTH-1:0]          load_ch_i,
    input  logic [RANK_WIDTH-1:0]        load_rank_i,
    output logic [NUM_CH-1:0]            shadow_vld_o,
    output logic [NUM_CH*RANK_WIDTH-1:0] shadow_rank_o
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic                  vld_q;
        logic [RANK_WIDTH-1:0] rank_q;
        logic                  hit;

        assign hit = load_i && (load_ch_i == CH_WIDTH'(c));

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_q  <= 1'b0;
                rank_q <= '0;
            end else begin
                vld_q <= hit;
                if (hit) rank_q <= load_rank_i;
            end
        end

        assign shadow_vld_o[c]                             = vld_q;
        assign shadow_rank_o[c*RANK_WIDTH +: RANK_WIDTH] = rank_q;
    end

endmodule

// File: rtl/pifo_bypass_checker_mc.sv
// Multi-channel PIFO bypass checker: one registered decision per accepted descriptor, choosing
// output queue (bypass) or per-channel calendar, with hazard shadowing and saturating stats.
module pifo_bypass_checker_mc
    import pifo_bypass_checker_mc_pkg::*;
#(
    parameter int PIFO_INFO_WIDTH = PIFO_INFO_WIDTH_DEF,
    parameter int RANK_LSB        = 0,
    parameter int RANK_WIDTH      = 16,
    parameter int CH_LSB          = 24,
    parameter int NUM_CH          = 4,
    parameter int CH_WIDTH        = 2,
    parameter int TIE_BYPASS      = 0,
    parameter int CNT_WIDTH       = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         s_axis_valid,
    output logic                         s_axis_ready,
    input  logic [PIFO_INFO_WIDTH-1:0]   s_axis_pifo_info,
    input  logic [NUM_CH*RANK_WIDTH-1:0] s_axis_cal_top,
    input  logic [NUM_CH-1:0]            s_axis_cal_nonempty,
    output logic                         m_axis_valid,
    input  logic                         m_axis_ready,
    output logic [PIFO_INFO_WIDTH-1:0]   m_axis_pifo_info,
    output logic [CH_WIDTH-1:0]          m_axis_ch,
    output logic                         m_axis_bypass_en,
    output logic                         m_axis_err,
    input  logic                         stat_clr,
    output logic [CNT_WIDTH-1:0]         stat_bypass_cnt,
    output logic [CNT_WIDTH-1:0]         stat_enq_cnt
);

    logic                         m_valid_q;
    logic [PIFO_INFO_WIDTH-1:0]   m_info_q;
    logic [CH_WIDTH-1:0]          m_ch_q;
    logic                         m_byp_q;
    logic                         m_err_q;
    logic [CNT_WIDTH-1:0]         byp_cnt_q;
    logic [CNT_WIDTH-1:0]         enq_cnt_q;

    logic                         accept;
    logic                         handshake;
    logic [RANK_WIDTH-1:0]        rank;
    logic [CH_WIDTH-1:0]          ch;
    logic [RANK_WIDTH-1:0]        m_rank;
    logic [NUM_CH-1:0]            sh_vld;
    logic [NUM_CH*RANK_WIDTH-1:0] sh_rank;

    logic                         ch_ok;
    logic [RANK_WIDTH-1:0]        top_sel;
    logic                         ne_sel;
    logic                         shv_sel;
    logic [RANK_WIDTH-1:0]        shr_sel;
    logic [RANK_WIDTH-1:0]        eff_top;
    logic                         eff_ne;
    logic                         byp_d;
    logic                         err_d;

    // Valid/ready: a transfer happens on any cycle with valid && ready on that side; a held
    // m_axis word never changes until it transfers, and s_axis is ready whenever the output
    // slot is empty or draining this cycle.
    assign s_axis_ready = !m_valid_q || m_axis_ready;
    assign accept       = s_axis_valid && s_axis_ready;
    assign handshake    = m_valid_q && m_axis_ready;

    assign rank   = RANK_WIDTH'(get_field(MAX_INFO_W'(s_axis_pifo_info), RANK_LSB, RANK_WIDTH));
    assign ch     = CH_WIDTH'(get_field(MAX_INFO_W'(s_axis_pifo_info), CH_LSB, CH_WIDTH));
    assign m_rank = RANK_WIDTH'(get_field(MAX_INFO_W'(m_info_q), RANK_LSB, RANK_WIDTH));

    always_comb begin
        ch_ok   = 1'b0;
        top_sel = '0;
        ne_sel  = 1'b0;
        shv_sel = 1'b0;
        shr_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == CH_WIDTH'(c)) begin
                ch_ok   = 1'b1;
                top_sel = s_axis_cal_top[c*RANK_WIDTH +: RANK_WIDTH];
                ne_sel  = s_axis_cal_nonempty[c];
                shv_sel = sh_vld[c];
                shr_sel = sh_rank[c*RANK_WIDTH +: RANK_WIDTH];
            end
        end
        // A live shadow and a fresh calendar top are merged by min(); neither wins outright.
        if (shv_sel) eff_top = (ne_sel && (top_sel < shr_sel)) ? top_sel : shr_sel;
        else         eff_top = top_sel;
        eff_ne = ne_sel || shv_sel;
        err_d  = !ch_ok;
        byp_d  = ch_ok && bypass_cmp(MAX_FIELD_W'(rank), MAX_FIELD_W'(eff_top), eff_ne,
                                     TIE_BYPASS != 0);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_valid_q <= 1'b0;
            m_info_q  <= '0;
            m_ch_q    <= '0;
            m_byp_q   <= 1'b0;
            m_err_q   <= 1'b0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_info_q  <= s_axis_pifo_info;
            m_ch_q    <= ch;
            m_byp_q   <= byp_d;
            m_err_q   <= err_d;
        end else if (handshake) begin
            m_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            byp_cnt_q <= '0;
            enq_cnt_q <= '0;
        end else if (stat_clr) begin
            byp_cnt_q <= '0;
            enq_cnt_q <= '0;
        end else if (handshake && !m_err_q) begin
            if (m_byp_q) begin
                if (byp_cnt_q != {CNT_WIDTH{1'b1}}) byp_cnt_q <= byp_cnt_q + CNT_WIDTH'(1);
            end else begin
                if (enq_cnt_q != {CNT_WIDTH{1'b1}}) enq_cnt_q <= enq_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    pifo_bypass_shadow #(
        .NUM_CH     (NUM_CH),
        .RANK_WIDTH (RANK_WIDTH),
        .CH_WIDTH   (CH_WIDTH)
    ) u_shadow (
        .clk           (clk),
        .rstn          (rstn),
        .load_i        (handshake && !m_byp_q && !m_err_q),
        .load_ch_i     (m_ch_q),
        .load_rank_i   (m_rank),
        .shadow_vld_o  (sh_vld),
        .shadow_rank_o (sh_rank)
    );

    assign m_axis_valid     = m_valid_q;
    assign m_axis_pifo_info = m_info_q;
    assign m_axis_ch        = m_ch_q;
    assign m_axis_bypass_en = m_byp_q;
    assign m_axis_err       = m_err_q;
    assign stat_bypass_cnt  = byp_cnt_q;
    assign stat_enq_cnt     = enq_cnt_q;

endmodule

// File: tb/tb_pifo_bypass_checker_mc.sv
// Bench for pifo_bypass_checker_mc: strict-tie and inclusive-tie instances share one stimulus
// stream; expected decisions are queued at issue time and popped by a monitor on handshakes.
module tb_pifo_bypass_checker_mc;

    localparam int W    = 32;
    localparam int RW   = 16;
    localparam int NC   = 4;
    localparam int CW   = 3;
    localparam int CNTW = 4;
    localparam int EW   = W + CW + 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic               s_valid;
    logic [W-1:0]       s_info;
    logic [NC*RW-1:0]   s_top;
    logic [NC-1:0]      s_ne;
    logic               m_ready;
    logic               stat_clr;

    logic               s_ready0, m_valid0, byp0, err0;
    logic [W-1:0]       info0;
    logic [CW-1:0]      ch0;
    logic [CNTW-1:0]    bcnt0, ecnt0;
    logic               s_ready1, m_valid1, byp1, err1;
    logic [W-1:0]       info1;
    logic [CW-1:0]      ch1;
    logic [CNTW-1:0]    bcnt1, ecnt1;

    pifo_bypass_checker_mc #(.PIFO_INFO_WIDTH(W), .RANK_LSB(0), .RANK_WIDTH(RW), .CH_LSB(24),
        .NUM_CH(NC), .CH_WIDTH(CW), .TIE_BYPASS(0), .CNT_WIDTH(CNTW)) dut0 (
        .clk(clk), .rstn(rstn), .s_axis_valid(s_valid), .s_axis_ready(s_ready0),
        .s_axis_pifo_info(s_info), .s_axis_cal_top(s_top), .s_axis_cal_nonempty(s_ne),
        .m_axis_valid(m_valid0), .m_axis_ready(m_ready), .m_axis_pifo_info(info0),
        .m_axis_ch(ch0), .m_axis_bypass_en(byp0), .m_axis_err(err0), .stat_clr(stat_clr),
        .stat_bypass_cnt(bcnt0), .stat_enq_cnt(ecnt0));

    pifo_bypass_checker_mc #(.PIFO_INFO_WIDTH(W), .RANK_LSB(0), .RANK_WIDTH(RW), .CH_LSB(24),
        .NUM_CH(NC), .CH_WIDTH(CW), .TIE_BYPASS(1), .CNT_WIDTH(CNTW)) dut1 (
        .clk(clk), .rstn(rstn), .s_axis_valid(s_valid), .s_axis_ready(s_ready1),
        .s_axis_pifo_info(s_info), .s_axis_cal_top(s_top), .s_axis_cal_nonempty(s_ne),
        .m_axis_valid(m_valid1), .m_axis_ready(m_ready), .m_axis_pifo_info(info1),
        .m_axis_ch(ch1), .m_axis_bypass_en(byp1), .m_axis_err(err1), .stat_clr(stat_clr),
        .stat_bypass_cnt(bcnt1), .stat_enq_cnt(ecnt1));

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    function automatic logic [W-1:0] mk(input int ch, input int rank);
        return (W'(ch) << 24) | W'(rank);
    endfunction

    function automatic logic [NC*RW-1:0] tops(input int t0, input int t1, input int t2, input int t3);
        return {RW'(t3), RW'(t2), RW'(t1), RW'(t0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word: {info, ch, err, bypass strict-tie, bypass inclusive-tie}
    task automatic send(input int ch, input int rank, input logic [NC*RW-1:0] top,
                        input logic [NC-1:0] ne, input logic e0, input logic e1, input logic er);
        int guard;
        @(negedge clk);
        s_valid = 1'b1;
        s_info  = mk(ch, rank);
        s_top   = top;
        s_ne    = ne;
        guard   = 0;
        while (!s_ready0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!s_ready0) check("accept_timeout", 64'(s_ready0), 64'd1);
        exp_q.push_back({mk(ch, rank), CW'(ch), er, e0, e1});
        @(posedge clk);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        s_valid = 1'b0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_cnt(input string name, input int b, input int e);
        #1;
        check({name, "_byp"}, 64'(bcnt0), 64'(b));
        check({name, "_enq"}, 64'(ecnt0), 64'(e));
    endtask

    initial begin : monitor
        logic [EW-1:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (rstn && m_valid0) begin
                got = {info0, ch0, err0, byp0, byp1};
                if (m_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_output", 64'(got), 64'd0);
                    end else begin
                        check("decision", 64'(got), 64'(exp_q[0]));
                        check("dut1_valid", 64'(m_valid1), 64'd1);
                        void'(exp_q.pop_front());
                    end
                end else if (exp_q.size() != 0) begin
                    check("stall_hold", 64'(got), 64'(exp_q[0]));
                end
            end
        end
    end

    initial begin : stim
        logic [NC*RW-1:0] t4, t20;
        int guard;
        s_valid  = 1'b0;
        s_info   = '0;
        s_top    = '0;
        s_ne     = '0;
        m_ready  = 1'b1;
        stat_clr = 1'b0;
        t4  = tops(0, 0, 4, 0);
        t20 = tops(0, 0, 20, 0);

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(m_valid0), 64'd0);
        check("rst_info",  64'(info0), 64'd0);
        check("rst_flags", 64'({ch0, byp0, err0}), 64'd0);
        check_cnt("rst_cnt", 0, 0);
        @(negedge clk);
        rstn = 1'b1;
        #1 check("rst_ready", 64'(s_ready0), 64'd1);

        send(0, 5, '0, 4'b0000, 1'b1, 1'b1, 1'b0);
        idle(3);
        check_cnt("cnt_first", 1, 0);

        send(1, 10, tops(0, 10, 0, 0), 4'b0010, 1'b0, 1'b1, 1'b0);
        send(1, 9,  tops(0, 10, 0, 0), 4'b0010, 1'b1, 1'b1, 1'b0);
        send(2, 8,  '0, 4'b0000, 1'b1, 1'b1, 1'b0);
        idle(3);
        check_cnt("cnt_tie", 3, 1);

        send(2, 7, t4,  4'b0100, 1'b0, 1'b0, 1'b0);
        send(2, 6, t4,  4'b0100, 1'b0, 1'b0, 1'b0);
        send(2, 6, t20, 4'b0100, 1'b1, 1'b1, 1'b0);
        send(2, 7, t20, 4'b0100, 1'b0, 1'b0, 1'b0);
        send(2, 8, '0,  4'b0000, 1'b1, 1'b1, 1'b0);
        send(2, 8, '0,  4'b0000, 1'b0, 1'b0, 1'b0);
        idle(3);
        check_cnt("cnt_shadow", 5, 5);

        send(5, 3, tops(100, 100, 100, 100), 4'b1111, 1'b0, 1'b0, 1'b1);
        idle(3);
        check_cnt("cnt_err", 5, 5);

        @(negedge clk);
        m_ready = 1'b0;
        send(0, 1, '0, 4'b0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        s_valid = 1'b1;
        s_info  = mk(3, 2);
        s_top   = tops(0, 0, 0, 1);
        s_ne    = 4'b1000;
        repeat (3) begin
            #1 check("stall_ready", 64'(s_ready0), 64'd0);
            @(negedge clk);
        end
        m_ready = 1'b1;
        exp_q.push_back({mk(3, 2), CW'(3), 1'b0, 1'b0, 1'b0});
        @(posedge clk);
        idle(3);
        check_cnt("cnt_stall", 6, 6);

        for (int i = 0; i < 10; i++) send(0, 20 + i, '0, 4'b0000, 1'b1, 1'b1, 1'b0);
        idle(3);
        check_cnt("cnt_sat", 15, 6);

        send(0, 1, '0, 4'b0000, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        s_valid  = 1'b0;
        stat_clr = 1'b1;
        @(negedge clk);
        stat_clr = 1'b0;
        check_cnt("cnt_clr", 0, 0);
        check("cnt_clr_dut1", 64'({bcnt1, ecnt1}), 64'd0);

        @(negedge clk);
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_info  = mk(0, 9);
        s_ne    = '0;
        @(negedge clk);
        s_valid = 1'b0;
        #1 check("held_valid", 64'(m_valid0), 64'd1);
        rstn = 1'b0;
        #1;
        check("midrst_valid", 64'(m_valid0), 64'd0);
        check("midrst_info",  64'(info0), 64'd0);
        @(negedge clk);
        rstn    = 1'b1;
        m_ready = 1'b1;
        #1 check("midrst_ready", 64'(s_ready0), 64'd1);

        send(2, 4, '0, 4'b0000, 1'b1, 1'b1, 1'b0);
        idle(3);

        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
